mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port memory arbiter that shares the single synchronous-RAM port between the CPU (port 0) and a secondary master such as DMA or debug (port 1). It sits between the masters and the memory macro. Requests are accepted with a req/gnt handshake, and completions come back one cycle later on rvalid. Arbitration is sticky round-robin: the current owner may keep the port for back-to-back requests, bounded by a burst limit so neither master starves.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte strobes are DATA_W/8 bits
- MAX_BURST, 4, max consecutive grants to one port while the other is requesting (≥1)
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- req0 / req1  in  1  request valid, port 0 / port 1
- addr0 / addr1  in  ADDR_W  request address
- wdata0 / wdata1  in  DATA_W  write data
- wstrb0 / wstrb1  in  DATA_W/8  byte write enables; all-zero means read
- gnt0 / gnt1  out  1  request accepted this cycle (combinational)
- rvalid0 / rvalid1  out  1  completion of request granted in previous cycle (registered)
- rdata  out  DATA_W  read data shared by both ports, valid with rvalid0/rvalid1; equals mem_rdata
- mem_en  out  1  memory access this cycle
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_wstrb  out  DATA_W/8  memory byte write enables
- mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_en (sync RAM)

## Operation
- Requester holds req, addr, wdata and wstrb stable until it sees gnt high on a rising edge. It may present a new request in the cycle after gnt.
- At most one gnt per cycle. mem_en = gnt0 | gnt1. mem_addr, mem_wdata and mem_wstrb are muxed from the granted port.
- When mem_en=0, mem_wstrb=0. mem_addr and mem_wdata are don't-care.
- State registers:
  - last: port granted most recently, 1 bit
  - cnt: consecutive grants to last, saturating at MAX_BURST
  - rv0, rv1: completion flags
- Grant rules:
  - Neither requesting: no grant; cnt←0.
  - Only port k requesting: grant k.
  - Both requesting, previous cycle granted last, and cnt<MAX_BURST: grant last (sticky).
  - Both requesting otherwise: grant the port ≠ last.
- cnt update on a grant:
  - Granted port == last and the previous cycle had a grant: cnt←cnt+1, saturating.
  - Otherwise: cnt←1, last←granted port.
- The completion flags assert one cycle after each grant: rv0←gnt0 and rv1←gnt1 every cycle.
- Writes also produce rvalid. rdata is don't-care on a write completion.

## Timing
- Reset values:
  - gnt0 and gnt1: 0 while rst_n=0
  - rvalid0, rvalid1, mem_en: 0
  - mem_wstrb: 0
  - last=1, so port 0 wins the first tie
  - cnt=0
- Latency:
  - Grant: 0 cycles after req if arbitration is won.
  - rvalid: exactly 1 cycle after gnt.
- Throughput: 1 access per cycle. Back-to-back grants to the same or alternating ports are allowed; the response of access N overlaps the issue of access N+1.
- A write at cycle T followed by a read of the same address at T+1 returns the new data (RAM write-first is not required; the write commits at edge T).
- Reset asserted mid-operation: pending rvalid is dropped (0 next cycle), no mem_en during reset, and the arbitration state is re-initialised.
- req dropping without gnt is illegal. Behaviour is undefined, but it must not produce a spurious rvalid.
- MAX_BURST=1 degenerates to strict alternation under contention.

## Test plan
- Single read, port 0: req0=1, addr0=0x10, wstrb0=0, with mem[0x10]=0xDEADBEEF → gnt0 at T, mem_en=1, mem_addr=0x10; rvalid0=1 and rdata=0xDEADBEEF at T+1; rvalid1 stays 0.
- Write then read, port 1: write 0xCAFEF00D with wstrb1=0xF to 0x20, then read 0x20 → gnt1 two consecutive cycles; second completion returns 0xCAFEF00D.
- Tie after reset: both req high from the first cycle out of reset, single-shot requests → gnt0 first, gnt1 next cycle; rvalid0 and rvalid1 each pulse once, in order.
- Burst limit: MAX_BURST=4, both requesting continuously → grant pattern 0,0,0,0,1,1,1,1,0… with no idle cycles; mem_en=1 every cycle.
- Byte strobe: write 0x000000AB with wstrb0=0x1 over 0x11223344 → subsequent read returns 0x112233AB.
- Reset mid-access: assert rst_n=0 in the cycle after gnt0 → rvalid0=0 that cycle and after. After release, a tie grants port 0.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Shared request/memory bus between the two masters, the arbiter and the RAM.
// slave is the arbiter's view; master is the requesters-plus-RAM view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic              req0;
  logic              req1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic [STRB_W-1:0] wstrb0;
  logic [STRB_W-1:0] wstrb1;
  logic              gnt0;
  logic              gnt1;
  logic              rvalid0;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [STRB_W-1:0] mem_wstrb;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req0, req1, addr0, addr1,
    input  wdata0, wdata1, wstrb0, wstrb1,
    output gnt0, gnt1, rvalid0, rvalid1, rdata,
    output mem_en, mem_addr, mem_wdata, mem_wstrb,
    input  mem_rdata
  );

  modport master (
    output req0, req1, addr0, addr1,
    output wdata0, wdata1, wstrb0, wstrb1,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata,
    input  mem_en, mem_addr, mem_wdata, mem_wstrb,
    output mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port sticky round-robin arbiter in front of a single sync-RAM port.
// Owner keeps the port for up to MAX_BURST back-to-back grants under contention.
module mem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_arbiter_if.slave bus
);
  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             last;
  logic [CNT_W-1:0] cnt;
  logic             rv0;
  logic             rv1;
  logic             had;
  logic             pick;
  logic             g0;
  logic             g1;
  logic             any;

  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [STRB_W-1:0] sel_strb;

  // pick names the winning port; only meaningful when a grant is issued
  always_comb begin
    had  = rv0 | rv1;
    pick = bus.req1;
    if (bus.req0 && bus.req1) begin
      if (had && cnt < CNT_MAX) pick = last;
      else pick = ~last;
    end
    g0  = rst_n & bus.req0 & ~pick;
    g1  = rst_n & bus.req1 & pick;
    any = g0 | g1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last <= 1'b1;
      cnt  <= '0;
      rv0  <= 1'b0;
      rv1  <= 1'b0;
    end else begin
      rv0 <= g0;
      rv1 <= g1;
      unique case (1'b1)
        !any: cnt <= '0;
        any && pick == last && had: begin
          if (cnt != CNT_MAX) cnt <= cnt + CNT_ONE;
        end
        default: begin
          cnt  <= CNT_ONE;
          last <= pick;
        end
      endcase
    end
  end

  assign sel_addr  = pick ? bus.addr1  : bus.addr0;
  assign sel_wdata = pick ? bus.wdata1 : bus.wdata0;
  assign sel_strb  = pick ? bus.wstrb1 : bus.wstrb0;

  assign bus.gnt0      = g0;
  assign bus.gnt1      = g1;
  assign bus.mem_en    = any;
  assign bus.mem_addr  = sel_addr;
  assign bus.mem_wdata = sel_wdata;
  assign bus.mem_wstrb = any ? sel_strb : '0;
  // a reset cycle hides any completion still in flight
  assign bus.rvalid0   = rv0 & rst_n;
  assign bus.rvalid1   = rv1 & rst_n;
  assign bus.rdata     = bus.mem_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// Random and directed bench for mem_arbiter against a grant-history model.
// Includes a behavioural sync RAM on the memory side.
module tb_mem_arbiter;
  localparam int MAXB = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .MAX_BURST(MAXB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  logic [31:0] ram [256];
  logic [31:0] ram_q;
  always @(posedge clk) begin
    if (bus.mem_en) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_wstrb[b])
          ram[bus.mem_addr[7:0]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      ram_q <= ram[bus.mem_addr[7:0]];
    end
  end
  assign bus.mem_rdata = ram_q;

  int checks = 0;
  int failures = 0;

  int last_port = 1;
  int run = 0;
  int prev_g = -1;
  logic [31:0] refm [256];
  bit known [256];
  bit pend_rd = 1'b0;
  bit pend_known = 1'b0;
  logic [31:0] pend_data;

  logic [1:0]  obs_gnt;
  logic [31:0] obs_rdata;
  logic        obs_rv0;

  bit          r [2];
  logic [31:0] a [2];
  logic [31:0] d [2];
  logic [3:0]  s [2];
  bit          busy [2];

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int model_grant();
    if (!rst_n) return -1;
    if (bus.req0 && !bus.req1) return 0;
    if (bus.req1 && !bus.req0) return 1;
    if (!bus.req0 && !bus.req1) return -1;
    if (prev_g >= 0 && run < MAXB) return last_port;
    return 1 - last_port;
  endfunction

  task automatic drive();
    bus.req0   = r[0];
    bus.addr0  = a[0];
    bus.wdata0 = d[0];
    bus.wstrb0 = s[0];
    bus.req1   = r[1];
    bus.addr1  = a[1];
    bus.wdata1 = d[1];
    bus.wstrb1 = s[1];
  endtask

  task automatic set(int k, bit rq, logic [31:0] ad,
                     logic [31:0] dt, logic [3:0] st);
    r[k] = rq;
    a[k] = ad;
    d[k] = dt;
    s[k] = st;
  endtask

  task automatic step();
    int g;
    logic [31:0] ad;
    logic [31:0] dt;
    logic [3:0] st;
    logic [7:0] idx;
    drive();
    #1;
    g = model_grant();
    ad = '0;
    dt = '0;
    st = '0;
    check("gnt0", bus.gnt0, g == 0);
    check("gnt1", bus.gnt1, g == 1);
    check("mem_en", bus.mem_en, g >= 0);
    if (g < 0) begin
      check("wstrb_idle", bus.mem_wstrb, 0);
    end else begin
      ad = a[g];
      dt = d[g];
      st = s[g];
      check("mem_addr", bus.mem_addr, ad);
      check("mem_wstrb", bus.mem_wstrb, st);
      if (st != 0) check("mem_wdata", bus.mem_wdata, dt);
    end
    check("rvalid0", bus.rvalid0, rst_n && prev_g == 0);
    check("rvalid1", bus.rvalid1, rst_n && prev_g == 1);
    if (rst_n && prev_g >= 0 && pend_rd && pend_known)
      check("rdata", bus.rdata, pend_data);
    obs_gnt   = {bus.gnt1, bus.gnt0};
    obs_rdata = bus.rdata;
    obs_rv0   = bus.rvalid0;
    @(posedge clk);
    if (!rst_n) begin
      last_port = 1;
      run = 0;
      prev_g = -1;
      pend_rd = 1'b0;
    end else begin
      if (g < 0) run = 0;
      else if (g == prev_g) run++;
      else begin
        run = 1;
        last_port = g;
      end
      prev_g = g;
      pend_rd = 1'b0;
      if (g >= 0) begin
        idx = ad[7:0];
        pend_rd = (st == 0);
        pend_known = known[idx];
        pend_data = refm[idx];
        if (st != 0) begin
          for (int b = 0; b < 4; b++)
            if (st[b]) refm[idx][8*b +: 8] = dt[8*b +: 8];
          known[idx] = known[idx] || (st == 4'hF);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    set(0, 0, 0, 0, 0);
    set(1, 0, 0, 0, 0);
  endtask

  initial begin
    logic [1:0] exp_g;
    for (int i = 0; i < 256; i++) known[i] = 1'b0;
    rst_n = 1'b0;
    idle();
    drive();
    @(negedge clk);
    step();
    step();
    rst_n = 1'b1;

    // tie straight out of reset
    set(0, 1, 32'h40, 0, 0);
    set(1, 1, 32'h44, 0, 0);
    step();
    check("tie_first", obs_gnt, 2'b01);
    set(0, 0, 0, 0, 0);
    step();
    check("tie_second", obs_gnt, 2'b10);
    idle();
    step();

    set(0, 1, 32'h10, 32'hDEADBEEF, 4'hF);
    step();
    set(0, 1, 32'h10, 0, 0);
    step();
    idle();
    step();
    check("single_rd", obs_rdata, 32'hDEADBEEF);

    set(1, 1, 32'h20, 32'hCAFEF00D, 4'hF);
    step();
    check("wr_p1_gnt", obs_gnt, 2'b10);
    set(1, 1, 32'h20, 0, 0);
    step();
    check("rd_p1_gnt", obs_gnt, 2'b10);
    idle();
    step();
    check("wr_rd_p1", obs_rdata, 32'hCAFEF00D);

    set(0, 1, 32'h30, 32'h11223344, 4'hF);
    step();
    set(0, 1, 32'h30, 32'h000000AB, 4'h1);
    step();
    set(0, 1, 32'h30, 0, 0);
    step();
    idle();
    step();
    check("byte_strobe", obs_rdata, 32'h112233AB);

    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3 * MAXB; i++) begin
      set(0, 1, 32'(i * 4), 0, 0);
      set(1, 1, 32'(64 + i * 4), 0, 0);
      step();
      exp_g = ((i / MAXB) % 2 == 1) ? 2'b10 : 2'b01;
      check("burst", obs_gnt, exp_g);
    end
    idle();
    step();

    set(0, 1, 32'h10, 0, 0);
    step();
    idle();
    rst_n = 1'b0;
    step();
    check("rst_rvalid0", obs_rv0, 0);
    step();
    rst_n = 1'b1;
    set(0, 1, 32'h48, 0, 0);
    set(1, 1, 32'h4C, 0, 0);
    step();
    check("rst_tie", obs_gnt, 2'b01);
    set(0, 0, 0, 0, 0);
    step();
    idle();
    step();

    busy[0] = 1'b0;
    busy[1] = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (!busy[k]) begin
          if ($urandom_range(0, 99) < 60) begin
            busy[k] = 1'b1;
            a[k] = 32'($urandom_range(0, 15)) << 2;
            d[k] = $urandom;
            case ($urandom_range(0, 3))
              0, 1: s[k] = 4'h0;
              2: s[k] = 4'hF;
              default: s[k] = 4'($urandom_range(1, 15));
            endcase
            r[k] = 1'b1;
          end else begin
            r[k] = 1'b0;
          end
        end
      end
      step();
      for (int k = 0; k < 2; k++)
        if (obs_gnt[k]) busy[k] = 1'b0;
    end
    idle();
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
